// File: rtl/ll_sync_pkg.sv
// Shared types and constants for the Logic Link receive strobe-sync detector.
package ll_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } ll_sync_state_e;

  localparam int LL_ERR_CNT_W = 16;
  localparam int LL_IV_W      = 8;

  // An interval of zero would never produce a strobe slot, so it behaves as 1.
  function automatic logic [LL_IV_W-1:0] ll_eff_interval(input logic [LL_IV_W-1:0] iv);
    return (iv == '0) ? LL_IV_W'(1) : iv;
  endfunction

endpackage

// File: rtl/ll_stb_interval_ctr.sv
// Strobe-slot counter: flags the word on which the next strobe is expected.
module ll_stb_interval_ctr
  import ll_sync_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [LL_IV_W-1:0] iv,
  input  logic               load,
  input  logic               run,
  output logic               exp
);

  logic [LL_IV_W-1:0] icnt;

  assign exp = (icnt == '0);

  // The reload happens on every expected slot, hit or miss, so the cadence never drifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= '0;
    end else if (clr) begin
      icnt <= '0;
    end else if (load) begin
      icnt <= iv - LL_IV_W'(1);
    end else if (run) begin
      icnt <= exp ? (iv - LL_IV_W'(1)) : (icnt - LL_IV_W'(1));
    end
  end

endmodule

// File: rtl/ll_rx_stb_sync_detect.sv
// Receive strobe cadence checker: hunts for the inserted strobe, verifies it, and gates rx data
// valid until lock is held.
module ll_rx_stb_sync_detect
  import ll_sync_pkg::*;
#(
  parameter int PHY_WIDTH    = 40,
  parameter int STB_BIT      = 39,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr,
  input  logic                    rx_online,
  input  logic [PHY_WIDTH-1:0]    rx_phy,
  input  logic [LL_IV_W-1:0]      stb_interval,
  input  logic                    err_clr,
  output logic [PHY_WIDTH-1:0]    rx_data,
  output logic                    rx_data_valid,
  output logic                    rx_sync_locked,
  output logic [1:0]              rx_sync_state,
  output logic [LL_ERR_CNT_W-1:0] rx_stb_err_cnt
);

  localparam logic [3:0]              LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0]              UNLOCK_N = 4'(UNLOCK_COUNT);
  localparam logic [LL_ERR_CNT_W-1:0] ERR_MAX  = '1;

  ll_sync_state_e state, state_nxt;
  logic [3:0]     good_cnt, good_nxt;
  logic [3:0]     miss_cnt, miss_nxt;
  logic           err_inc;
  logic           ctr_load, ctr_run, exp;
  logic           stb;

  assign stb           = rx_phy[STB_BIT];
  assign rx_sync_state = state;

  ll_stb_interval_ctr u_ctr (
    .clk  (clk_wr),
    .rst  (rst_wr),
    .clr  (!rx_online),
    .iv   (ll_eff_interval(stb_interval)),
    .load (ctr_load),
    .run  (ctr_run),
    .exp  (exp)
  );

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    err_inc   = 1'b0;
    ctr_load  = 1'b0;
    ctr_run   = 1'b0;
    if (!rx_online) begin
      state_nxt = IDLE;
      good_nxt  = '0;
      miss_nxt  = '0;
    end else begin
      case (state)
        IDLE: state_nxt = HUNT;
        HUNT: begin
          if (stb) begin
            state_nxt = VERIFY;
            ctr_load  = 1'b1;
            good_nxt  = 4'd1;
          end
        end
        VERIFY: begin
          ctr_run = 1'b1;
          if (exp && stb) begin
            good_nxt = good_cnt + 4'd1;
            if (good_nxt == LOCK_N) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else if (stb != exp) begin
            // The offending strobe is dropped; HUNT waits for a fresh one.
            state_nxt = HUNT;
            good_nxt  = '0;
            err_inc   = 1'b1;
          end
        end
        LOCKED: begin
          ctr_run = 1'b1;
          if (exp && stb) begin
            miss_nxt = '0;
          end else if (stb != exp) begin
            miss_nxt = miss_cnt + 4'd1;
            err_inc  = 1'b1;
            if (miss_nxt == UNLOCK_N) begin
              state_nxt = HUNT;
              miss_nxt  = '0;
              good_nxt  = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state          <= IDLE;
      good_cnt       <= '0;
      miss_cnt       <= '0;
      rx_stb_err_cnt <= '0;
      rx_data        <= '0;
      rx_data_valid  <= 1'b0;
      rx_sync_locked <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      miss_cnt <= miss_nxt;
      if (err_clr) begin
        rx_stb_err_cnt <= '0;
      end else if (err_inc && (rx_stb_err_cnt != ERR_MAX)) begin
        rx_stb_err_cnt <= rx_stb_err_cnt + LL_ERR_CNT_W'(1);
      end
      rx_data        <= rx_phy;
      // Uses the pre-edge state: the lock-completing word itself is not flagged valid.
      rx_data_valid  <= (state == LOCKED) && rx_online;
      rx_sync_locked <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_ll_rx_stb_sync_detect.sv
// Directed bench for ll_rx_stb_sync_detect: lock, early strobe, loss of lock, short intervals,
// link drop, async reset and error-counter saturation.
module tb_ll_rx_stb_sync_detect;

  localparam int W = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          rx_online = 1'b0;
  logic [W-1:0]  rx_phy = '0;
  logic [7:0]    stb_interval = 8'd0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  rx_data;
  logic          rx_data_valid;
  logic          rx_sync_locked;
  logic [1:0]    rx_sync_state;
  logic [15:0]   rx_stb_err_cnt;

  logic          s_online = 1'b0;
  logic [W-1:0]  s_phy = '0;
  logic [7:0]    s_iv = 8'd0;
  logic          s_clr = 1'b0;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_locked;
  logic [1:0]    s_state;
  logic [15:0]   s_err;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  last_phy = '0;

  always #5 clk = ~clk;

  ll_rx_stb_sync_detect dut (
    .clk_wr         (clk),
    .rst_wr         (rst),
    .rx_online      (rx_online),
    .rx_phy         (rx_phy),
    .stb_interval   (stb_interval),
    .err_clr        (err_clr),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_sync_locked (rx_sync_locked),
    .rx_sync_state  (rx_sync_state),
    .rx_stb_err_cnt (rx_stb_err_cnt)
  );

  // Fast-lock / long-tolerance instance so saturation is reachable in a short run.
  ll_rx_stb_sync_detect #(.LOCK_COUNT(2), .UNLOCK_COUNT(15)) dut_sat (
    .clk_wr         (clk),
    .rst_wr         (rst),
    .rx_online      (s_online),
    .rx_phy         (s_phy),
    .stb_interval   (s_iv),
    .err_clr        (s_clr),
    .rx_data        (s_data),
    .rx_data_valid  (s_valid),
    .rx_sync_locked (s_locked),
    .rx_sync_state  (s_state),
    .rx_stb_err_cnt (s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic word(input logic s);
    rx_phy   = {s, 7'($urandom), 32'($urandom)};
    last_phy = rx_phy;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) word(1'b0);
  endtask

  task automatic sword(input logic s);
    s_phy = {s, 39'd0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, checked while rst is held
    #3;
    chk("rst_state",  64'(rx_sync_state), 64'd0);
    chk("rst_locked", 64'(rx_sync_locked), 64'd0);
    chk("rst_valid",  64'(rx_data_valid), 64'd0);
    chk("rst_data",   64'(rx_data), 64'd0);
    chk("rst_err",    64'(rx_stb_err_cnt), 64'd0);
    chk("rst_s_err",  64'(s_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    word(1'b0);
    chk("offline_idle", 64'(rx_sync_state), 64'd0);
    chk("data_reg", 64'(rx_data), 64'(last_phy));

    // Lock acquisition, iv=4, strobes on words 0,4,8,12
    rx_online    = 1'b1;
    stb_interval = 8'd4;
    word(1'b0);
    chk("idle_to_hunt", 64'(rx_sync_state), 64'd1);
    word(1'b1);
    chk("w0_verify", 64'(rx_sync_state), 64'd2);
    gap(3); word(1'b1);
    gap(3); word(1'b1);
    chk("w8_verify", 64'(rx_sync_state), 64'd2);
    chk("w8_unlocked", 64'(rx_sync_locked), 64'd0);
    gap(3); word(1'b1);
    chk("w12_locked", 64'(rx_sync_locked), 64'd1);
    chk("w12_state", 64'(rx_sync_state), 64'd3);
    chk("w12_valid", 64'(rx_data_valid), 64'd0);
    word(1'b0);
    chk("w13_valid", 64'(rx_data_valid), 64'd1);
    chk("w13_data", 64'(rx_data), 64'(last_phy));
    chk("lock_err", 64'(rx_stb_err_cnt), 64'd0);

    // Switch to iv=8 while locked: old icnt (2) runs out first, then reloads to 7
    stb_interval = 8'd8;
    gap(2); word(1'b1);
    chk("iv8_first_slot", 64'(rx_stb_err_cnt), 64'd0);
    gap(7); word(1'b0);
    gap(7); word(1'b0);
    chk("two_miss_err", 64'(rx_stb_err_cnt), 64'd2);
    chk("two_miss_locked", 64'(rx_sync_locked), 64'd1);
    gap(7); word(1'b1);
    chk("recover_locked", 64'(rx_sync_locked), 64'd1);
    gap(7); word(1'b0);
    gap(7); word(1'b0);
    chk("miss2_locked", 64'(rx_sync_locked), 64'd1);
    gap(7); word(1'b0);
    chk("miss3_state", 64'(rx_sync_state), 64'd1);
    chk("miss3_locked", 64'(rx_sync_locked), 64'd0);
    chk("miss3_err", 64'(rx_stb_err_cnt), 64'd5);
    word(1'b0);
    chk("unlock_valid", 64'(rx_data_valid), 64'd0);

    // Early strobe, iv=4, strobes on words 0,4,6 then 10,14,18,22
    stb_interval = 8'd4;
    word(1'b1);
    gap(3); word(1'b1);
    word(1'b0); word(1'b1);
    chk("early_state", 64'(rx_sync_state), 64'd1);
    chk("early_err", 64'(rx_stb_err_cnt), 64'd6);
    gap(3);
    chk("early_no_reuse", 64'(rx_sync_state), 64'd1);
    word(1'b1);
    chk("w10_verify", 64'(rx_sync_state), 64'd2);
    gap(3); word(1'b1);
    gap(3); word(1'b1);
    chk("w18_verify", 64'(rx_sync_state), 64'd2);
    gap(3); word(1'b1);
    chk("w22_locked", 64'(rx_sync_state), 64'd3);

    // iv=0 behaves as 1: strobe on every word
    rx_online = 1'b0;
    word(1'b0);
    chk("drop_idle", 64'(rx_sync_state), 64'd0);
    chk("drop_err_held", 64'(rx_stb_err_cnt), 64'd6);
    chk("drop_valid", 64'(rx_data_valid), 64'd0);
    rx_online    = 1'b1;
    stb_interval = 8'd0;
    word(1'b0);
    word(1'b1); word(1'b1); word(1'b1);
    chk("iv0_verify", 64'(rx_sync_state), 64'd2);
    word(1'b1);
    chk("iv0_locked", 64'(rx_sync_state), 64'd3);

    // iv=1: one missing strobe during VERIFY
    rx_online = 1'b0;
    word(1'b0);
    rx_online    = 1'b1;
    stb_interval = 8'd1;
    word(1'b0);
    word(1'b1); word(1'b1); word(1'b0);
    chk("iv1_miss_state", 64'(rx_sync_state), 64'd1);
    chk("iv1_miss_err", 64'(rx_stb_err_cnt), 64'd7);

    // rx_online drop mid-VERIFY
    stb_interval = 8'd4;
    word(1'b1); word(1'b0);
    chk("pre_drop_verify", 64'(rx_sync_state), 64'd2);
    rx_online = 1'b0;
    word(1'b0);
    chk("vdrop_state", 64'(rx_sync_state), 64'd0);
    chk("vdrop_err", 64'(rx_stb_err_cnt), 64'd7);

    // Async reset mid-LOCKED
    rx_online    = 1'b1;
    stb_interval = 8'd1;
    word(1'b0);
    word(1'b1); word(1'b1); word(1'b1); word(1'b1);
    word(1'b1);
    chk("pre_rst_valid", 64'(rx_data_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 64'(rx_sync_state), 64'd0);
    chk("arst_locked", 64'(rx_sync_locked), 64'd0);
    chk("arst_valid", 64'(rx_data_valid), 64'd0);
    chk("arst_data", 64'(rx_data), 64'd0);
    chk("arst_err", 64'(rx_stb_err_cnt), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    rx_online = 1'b0;

    // Saturation on the second instance: iv=1, 14 misses then one good strobe per round
    s_online = 1'b1;
    s_iv     = 8'd1;
    sword(1'b0);
    sword(1'b1); sword(1'b1);
    chk("sat_locked", 64'(s_locked), 64'd1);
    for (int j = 0; j < 14; j++) sword(1'b0);
    sword(1'b1);
    chk("sat_round1", 64'(s_err), 64'd14);
    for (int k = 1; k < 4681; k++) begin
      for (int j = 0; j < 14; j++) sword(1'b0);
      sword(1'b1);
    end
    chk("sat_fffe", 64'(s_err), 64'hFFFE);
    chk("sat_still_locked", 64'(s_locked), 64'd1);
    sword(1'b0);
    chk("sat_ffff", 64'(s_err), 64'hFFFF);
    sword(1'b0);
    chk("sat_hold", 64'(s_err), 64'hFFFF);
    sword(1'b1);
    s_clr = 1'b1;
    sword(1'b0);
    chk("clr_wins", 64'(s_err), 64'd0);
    s_clr = 1'b0;
    sword(1'b0);
    chk("post_clr_inc", 64'(s_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
